imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate extender: packs a 32-bit immediate into the
//  I/S/B/J/U immediate field positions of a base instruction word and flags
//  immediates that cannot be encoded. Feeds self-test and program-builder paths.
//  It is a 2-stage valid/ready pipeline: S1 = range check, S2 = output register.
// PARAMETERS
//  ERR_CNT_W     16  width of the saturating error counter
//  STRICT_ALIGN  1   1: nonzero imm[0] on B/J sets err; 0: imm[0] is dropped silently
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   request present
//  in_ready   out  1   request accepted when in_valid & in_ready
//  in_immsrc  in   3   000 I, 001 S, 010 B, 011 J, 100 U, others illegal
//  in_imm     in   32  immediate value, two's complement
//  in_base    in   32  instruction word; bits in the imm field positions are ignored
//  out_valid  out  1   result present
//  out_ready  in   1   result consumed when out_valid & out_ready
//  out_instr  out  32  encoded instruction
//  out_err    out  1   immediate not encodable for this type
//  err_count  out  ERR_CNT_W  number of transferred results with err=1, saturating
// BEHAVIOUR
//  Reset: S1/S2 emptied, out_valid=0, out_instr=0, out_err=0, err_count=0.
//   A reset mid-operation drops all in-flight words. No output appears from them.
//  Field packing (bits not named below come from in_base):
//   I: [31:20]=imm[11:0]                      legal iff imm[31:11] all equal
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]     legal iff imm[31:11] all equal
//   B: [31]=imm[12],[30:25]=imm[10:5],[11:8]=imm[4:1],[7]=imm[11]
//                                             legal iff imm[31:12] all equal
//   J: [31]=imm[20],[30:21]=imm[10:1],[20]=imm[11],[19:12]=imm[19:12]
//                                             legal iff imm[31:20] all equal
//   U: [31:12]=imm[31:12]                     legal iff imm[11:0]==0
//   B/J with imm[0]=1: err=1 when STRICT_ALIGN=1. Packing still uses the fields above.
//   Illegal immsrc: out_instr=in_base unchanged, err=1.
//   On err the packed fields still hold the truncated bits. No exception is raised.
//  Round-trip: if err=0, extending out_instr with the same immsrc returns in_imm.
//  Pipeline:
//   s2_adv = !out_valid | out_ready;  s1_adv = s1_valid & s2_adv
//   in_ready = !s1_valid | s2_adv  (combinational from out_ready; must be 1 after reset)
//   Latency: 2 cycles from acceptance to out_valid when out_ready is held high.
//   Throughput: 1 word/cycle.
//  Back-pressure and ordering:
//   With out_ready=0, at most 2 words are held. Words are neither lost nor duplicated.
//   Order is preserved.
//   out_instr and out_err stay stable while out_valid & !out_ready.
//  Simultaneous events: accept into S1, S1->S2 and S2 drain can all occur in one cycle.
//  err_count: +1 on each out_valid & out_ready & out_err. It holds at all-ones.
// TESTING
//  I, imm=0xFFFFFFFF, base=0x00000013 -> out_instr=0xFFF00013, err=0, 2 cycles later
//  B, imm=8, base=0x00000063 -> 0x00000463, err=0
//  J, imm=0x00100000 -> err=1, err_count 0->1 at transfer
//  U, imm=0x12345000, base=0x00000037 -> 0x12345037, err=0; U, imm=0x12345001 -> err=1
//  Hold out_ready=0 for 5 cycles while 3 requests are offered:
//   in_ready drops after 2 accepts; all 3 exit in order once out_ready=1
//  Reset asserted with 2 words in flight -> out_valid=0 the next cycle, no stale output,
//   err_count=0
//  Random 10k legal (immsrc, imm) pairs: extend(out_instr) == imm, and all non-imm bits
//   equal in_base. With ERR_CNT_W=2, 5 errors -> err_count saturates at 3.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U field positions of a base instruction
// word, flagging immediates that do not fit; two-stage valid/ready pipeline.
module imm_encoder #(
    parameter int ERR_CNT_W    = 16,
    parameter bit STRICT_ALIGN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_immsrc,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    logic [31:0] field_mask;
    logic [31:0] field_bits;
    logic        fits;
    logic        misaligned;
    logic [31:0] enc_instr;

    logic                 s1_valid_reg;
    logic [31:0]          s1_instr_reg;
    logic                 s1_err_reg;
    logic                 out_valid_reg;
    logic [31:0]          out_instr_reg;
    logic                 out_err_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign misaligned = STRICT_ALIGN && in_imm[0];

    // Sign-range checks: the bits above the top encodable bit must all match it.
    always_comb begin
        field_mask = 32'h0000_0000;
        field_bits = 32'h0000_0000;
        fits       = 1'b0;
        case (in_immsrc)
            SRC_I: begin
                field_mask = 32'hFFF0_0000;
                field_bits = {in_imm[11:0], 20'b0};
                fits       = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            SRC_S: begin
                field_mask = 32'hFE00_0F80;
                field_bits = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                fits       = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            SRC_B: begin
                field_mask = 32'hFE00_0F80;
                field_bits = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                fits       = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~misaligned;
            end
            SRC_J: begin
                field_mask = 32'hFFFF_F000;
                field_bits = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                fits       = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~misaligned;
            end
            SRC_U: begin
                field_mask = 32'hFFFF_F000;
                field_bits = {in_imm[31:12], 12'b0};
                fits       = ~(|in_imm[11:0]);
            end
            default: begin
                field_mask = 32'h0000_0000;
                field_bits = 32'h0000_0000;
                fits       = 1'b0;
            end
        endcase
        enc_instr = (in_base & ~field_mask) | field_bits;
    end

    assign s2_adv   = ~out_valid_reg | out_ready;
    assign s1_adv   = s1_valid_reg & s2_adv;
    assign in_ready = ~s1_valid_reg | s2_adv;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_instr_reg  <= 32'h0000_0000;
            s1_err_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'h0000_0000;
            out_err_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_instr_reg <= enc_instr;
                s1_err_reg   <= ~fits;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end

            // Output data only changes when a new word moves in, so it holds under stall.
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_instr_reg <= s1_instr_reg;
                    out_err_reg   <= s1_err_reg;
                end
            end

            if (out_valid_reg && out_ready && out_err_reg && !(&err_count_reg)) begin
                err_count_reg <= err_count_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_err   = out_err_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, back-pressure and reset sequences, and
// random legal immediates checked by decoding the output back to the immediate.
module tb_imm_encoder;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] instr;
        logic        err;
        logic        exact;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_immsrc = 3'd0;
    logic [31:0] in_imm = 32'h0;
    logic [31:0] in_base = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [1:0]  err_count;

    int tests_run = 0;
    int tests_failed = 0;
    int accepts = 0;
    int txns = 0;
    int model_cnt = 0;
    logic        held = 1'b0;
    logic [31:0] held_instr = 32'h0;
    logic        held_err = 1'b0;

    item_t pend_q[$];
    item_t exp_q[$];
    item_t tbl[14];

    imm_encoder #(
        .ERR_CNT_W   (2),
        .STRICT_ALIGN(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_immsrc(in_immsrc),
        .in_imm   (in_imm),
        .in_base  (in_base),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_err  (out_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Encodability stated as a signed numeric range plus alignment.
    function automatic logic legal(input logic [2:0] s, input logic [31:0] v);
        int x;
        x = v;
        case (s)
            3'd0, 3'd1: return (x >= -2048) && (x <= 2047);
            3'd2:       return (x >= -4096) && (x <= 4095) && (x % 2 == 0);
            3'd3:       return (x >= -(1 << 20)) && (x < (1 << 20)) && (x % 2 == 0);
            3'd4:       return (x % 4096) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    // Immediate extender (decoder side), the inverse of the unit under test.
    function automatic logic [31:0] extend(input logic [2:0] s, input logic [31:0] i);
        case (s)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4:    return {i[31:12], 12'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] imm_mask(input logic [2:0] s);
        case (s)
            3'd0:       return 32'hFFF0_0000;
            3'd1, 3'd2: return 32'hFE00_0F80;
            3'd3, 3'd4: return 32'hFFFF_F000;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic item_t rand_legal();
        item_t it;
        logic [31:0] r;
        r = $urandom;
        it.src = 3'($urandom_range(0, 4));
        case (it.src)
            3'd0, 3'd1: it.imm = {{20{r[11]}}, r[11:0]};
            3'd2:       it.imm = {{19{r[12]}}, r[12:1], 1'b0};
            3'd3:       it.imm = {{11{r[20]}}, r[20:1], 1'b0};
            default:    it.imm = {r[31:12], 12'b0};
        endcase
        it.base  = $urandom;
        it.instr = 32'h0;
        it.err   = ~legal(it.src, it.imm);
        it.exact = 1'b0;
        return it;
    endfunction

    // One cycle: set inputs at the falling edge, then check outputs and drive requests.
    task automatic tick(input logic rdy, input logic rst);
        item_t e;
        @(negedge clk);
        out_ready = rdy;
        reset = rst;
        #1;
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
            held = 1'b0;
            in_valid = 1'b0;
        end else begin
            check("err_count", 32'(err_count), 32'(model_cnt));
            if (out_valid) begin
                if (held) begin
                    check("hold_instr", out_instr, held_instr);
                    check("hold_err", 32'(out_err), 32'(held_err));
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        txns++;
                        $display("[TB] txn %0d src=%0d imm=%h base=%h -> instr=%h err=%0d",
                                 txns, e.src, e.imm, e.base, out_instr, out_err);
                        check("out_err", 32'(out_err), 32'(e.err));
                        if (e.exact) begin
                            check("out_instr", out_instr, e.instr);
                        end else begin
                            check("roundtrip", extend(e.src, out_instr), e.imm);
                            check("base_bits", out_instr & ~imm_mask(e.src),
                                  e.base & ~imm_mask(e.src));
                        end
                        if (e.err && model_cnt < 3) model_cnt++;
                    end
                end else begin
                    held = 1'b1;
                    held_instr = out_instr;
                    held_err = out_err;
                end
            end else begin
                held = 1'b0;
            end

            if (pend_q.size() != 0) begin
                in_valid  = 1'b1;
                in_immsrc = pend_q[0].src;
                in_imm    = pend_q[0].imm;
                in_base   = pend_q[0].base;
                if (in_ready) begin
                    exp_q.push_back(pend_q.pop_front());
                    accepts++;
                end
            end else begin
                in_valid  = 1'b0;
                in_immsrc = 3'($urandom_range(0, 7));
                in_imm    = $urandom;
                in_base   = $urandom;
            end
        end
    endtask

    task automatic drain(input int bound, input logic rand_rdy);
        int n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
            tick(rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
            n++;
        end
        check("drain_timeout", 32'(pend_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        int start_acc;
        tbl[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0, 1'b1};
        tbl[1]  = '{3'd2, 32'h0000_0008, 32'h0000_0063, 32'h0000_0463, 1'b0, 1'b1};
        tbl[2]  = '{3'd3, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1, 1'b1};
        tbl[3]  = '{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0, 1'b1};
        tbl[4]  = '{3'd4, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1, 1'b1};
        tbl[5]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_2023, 32'hFE00_2FA3, 1'b0, 1'b1};
        tbl[6]  = '{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, 1'b1};
        tbl[7]  = '{3'd0, 32'h0000_07FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[8]  = '{3'd2, 32'h0000_0007, 32'h0000_0063, 32'h0000_0363, 1'b1, 1'b1};
        tbl[9]  = '{3'd5, 32'h0000_0123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1};
        tbl[10] = '{3'd3, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0, 1'b1};
        tbl[11] = '{3'd2, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0, 1'b1};
        tbl[12] = '{3'd1, 32'hFFFF_F800, 32'h0000_0023, 32'h8000_0023, 1'b0, 1'b1};
        tbl[13] = '{3'd4, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0FFF, 1'b0, 1'b1};

        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);

        // Two-cycle latency on an empty pipeline.
        pend_q.push_back(tbl[0]);
        tick(1'b1, 1'b0);
        check("lat_accept", 32'(accepts), 32'd1);
        tick(1'b1, 1'b0);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        tick(1'b1, 1'b0);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        drain(20, 1'b0);

        // Five erroring vectors in here push the 2-bit counter to saturation.
        for (int i = 1; i < 14; i++) pend_q.push_back(tbl[i]);
        drain(100, 1'b0);
        tick(1'b1, 1'b0);
        check("err_count_saturated", 32'(err_count), 32'd3);

        // Back-pressure: three offered, two held, all three delivered in order.
        start_acc = accepts;
        for (int i = 0; i < 3; i++) pend_q.push_back(rand_legal());
        repeat (5) tick(1'b0, 1'b0);
        check("bp_accepts", 32'(accepts - start_acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        drain(20, 1'b0);
        check("bp_total", 32'(accepts - start_acc), 32'd3);

        // Reset with two words in flight must drop them.
        start_acc = accepts;
        for (int i = 0; i < 2; i++) pend_q.push_back(tbl[2]);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("flight_accepts", 32'(accepts - start_acc), 32'd2);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_instr", out_instr, 32'h0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (4) tick(1'b1, 1'b0);
        check("midrst_quiet", 32'(out_valid), 32'd0);

        for (int i = 0; i < 10000; i++) pend_q.push_back(rand_legal());
        drain(50000, 1'b1);
        tick(1'b1, 1'b0);
        check("random_err_count", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
